// File: rtl/mems_spi_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | mems_spi_pkg
// | Shared types and defaults for the MEMS SPI arbiter.
// | Revision: 1.0
// +---------------------------------------------------------------------------
package mems_spi_pkg;

    localparam int DEF_DATA_W      = 24;
    localparam int DEF_ACK_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_SCAN = 2'b01,
        GRANT_HOST = 2'b10
    } grant_t;

    // On a tie the requester that was not served last wins.
    function automatic grant_t pick_grant(input logic scan_pend,
                                          input logic host_pend,
                                          input grant_t last_grant);
        grant_t result;
        result = GRANT_NONE;
        if (scan_pend && host_pend) begin
            result = (last_grant == GRANT_SCAN) ? GRANT_HOST : GRANT_SCAN;
        end else if (scan_pend) begin
            result = GRANT_SCAN;
        end else if (host_pend) begin
            result = GRANT_HOST;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mems_spi_req_slot.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | mems_spi_req_slot
// | Single-entry request slot: pending latch, word capture, overrun detect.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module mems_spi_req_slot
    import mems_spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              take,
    input  logic              granted,
    input  logic              rel,
    output logic              pending,
    output logic [DATA_W-1:0] word,
    output logic              busy,
    output logic              overrun
);

    logic              pending_q;
    logic              pending_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic              slot_full;

    // The slot counts as free in the cycle the arbiter releases it.
    always_comb begin
        slot_full = pending_q | (granted & ~rel);
        overrun   = start & slot_full;
        pending_d = pending_q;
        word_d    = word_q;
        if (take) begin
            pending_d = 1'b0;
        end
        if (start && !slot_full) begin
            pending_d = 1'b1;
            word_d    = data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            word_q    <= '0;
        end else begin
            pending_q <= pending_d;
            word_q    <= word_d;
        end
    end

    assign pending = pending_q;
    assign word    = word_q;
    assign busy    = pending_q | granted;

endmodule
`default_nettype wire

// File: rtl/mems_spi_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | mems_spi_arbiter
// | Arbitrates scan and host command requests onto one shared SPI master.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module mems_spi_arbiter
    import mems_spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    input  logic [DATA_W-1:0] scan_data,
    output logic              scan_busy,
    input  logic              host_start,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_busy,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    input  logic              spi_busy,
    output logic [1:0]        grant,
    input  logic              err_clr,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    state_t            state_q;
    grant_t            grant_q;
    grant_t            last_grant_q;
    logic              spi_start_q;
    logic [DATA_W-1:0] spi_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_overrun_q;
    logic              err_timeout_q;

    logic              scan_pend;
    logic              host_pend;
    logic [DATA_W-1:0] scan_word;
    logic [DATA_W-1:0] host_word;
    logic              scan_ovr;
    logic              host_ovr;
    logic              scan_granted;
    logic              host_granted;
    grant_t            pick;
    logic              take_scan;
    logic              take_host;
    logic              ack_expired;
    logic              xfer_done;
    logic              rel_scan;
    logic              rel_host;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        pick         = pick_grant(scan_pend, host_pend, last_grant_q);
        take_scan    = (state_q == ST_IDLE) && (pick == GRANT_SCAN);
        take_host    = (state_q == ST_IDLE) && (pick == GRANT_HOST);
        scan_granted = (grant_q == GRANT_SCAN);
        host_granted = (grant_q == GRANT_HOST);
        ack_expired  = (state_q == ST_WAIT_ACK) && !spi_busy && (cnt_q == CNT_MAX);
        xfer_done    = (state_q == ST_WAIT_DONE) && !spi_busy;
        rel_scan     = (ack_expired || xfer_done) && scan_granted;
        rel_host     = (ack_expired || xfer_done) && host_granted;
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    mems_spi_req_slot #(
        .DATA_W (DATA_W)
    ) u_scan_slot (
        .clk     (clk),
        .rst     (rst),
        .start   (scan_start),
        .data    (scan_data),
        .take    (take_scan),
        .granted (scan_granted),
        .rel     (rel_scan),
        .pending (scan_pend),
        .word    (scan_word),
        .busy    (scan_busy),
        .overrun (scan_ovr)
    );

    mems_spi_req_slot #(
        .DATA_W (DATA_W)
    ) u_host_slot (
        .clk     (clk),
        .rst     (rst),
        .start   (host_start),
        .data    (host_data),
        .take    (take_host),
        .granted (host_granted),
        .rel     (rel_host),
        .pending (host_pend),
        .word    (host_word),
        .busy    (host_busy),
        .overrun (host_ovr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= GRANT_NONE;
            last_grant_q  <= GRANT_HOST;
            spi_start_q   <= 1'b0;
            spi_data_q    <= '0;
            cnt_q         <= '0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // A new error in the clear cycle wins over the clear.
            err_overrun_q <= (err_overrun_q & ~err_clr) | scan_ovr | host_ovr;
            err_timeout_q <= (err_timeout_q & ~err_clr) | ack_expired;
            spi_start_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick != GRANT_NONE) begin
                        grant_q     <= pick;
                        spi_start_q <= 1'b1;
                        spi_data_q  <= (pick == GRANT_SCAN) ? scan_word : host_word;
                        cnt_q       <= '0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= cnt_inc;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (spi_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (ack_expired) begin
                        grant_q <= GRANT_NONE;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        last_grant_q <= grant_q;
                        grant_q      <= GRANT_NONE;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= GRANT_NONE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_start   = spi_start_q;
    assign spi_data    = spi_data_q;
    assign grant       = grant_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mems_spi_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | tb_mems_spi_arbiter
// | Directed self-checking bench for the MEMS SPI arbiter.
// | Revision: 1.0
// +---------------------------------------------------------------------------
module tb_mems_spi_arbiter;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_start;
    logic [DW-1:0] scan_data;
    logic          scan_busy;
    logic          host_start;
    logic [DW-1:0] host_data;
    logic          host_busy;
    logic          spi_start;
    logic [DW-1:0] spi_data;
    logic          spi_busy;
    logic [1:0]    grant;
    logic          err_clr;
    logic          err_overrun;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    mems_spi_arbiter #(
        .DATA_W      (DW),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_start  (scan_start),
        .scan_data   (scan_data),
        .scan_busy   (scan_busy),
        .host_start  (host_start),
        .host_data   (host_data),
        .host_busy   (host_busy),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_busy    (spi_busy),
        .grant       (grant),
        .err_clr     (err_clr),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; scan_start = 1'b0; host_start = 1'b0;
        scan_data = '0; host_data = '0; spi_busy = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b want 0", spi_start); end
        checks++; if (spi_data !== 24'h0) begin errors++; $display("FAIL reset_spi_data: got %h want 000000", spi_data); end
        checks++; if ({scan_busy, host_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {scan_busy, host_busy}); end
        checks++; if ({err_overrun, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {err_overrun, err_timeout}); end
        tick();
    endtask

    // Start in cycle 10, spi_start in 12, spi_busy from 13 until it drops in 40.
    task automatic test_single();
        tick();
        scan_start = 1'b1; scan_data = 24'h300123;
        tick();
        scan_start = 1'b0;
        checks++; if ({scan_busy, spi_start} !== 2'b10) begin errors++; $display("FAIL single_pending: got busy,start=%b want 10", {scan_busy, spi_start}); end
        tick();
        checks++; if (spi_start !== 1'b1) begin errors++; $display("FAIL single_spi_start: got %b want 1", spi_start); end
        checks++; if (spi_data !== 24'h300123) begin errors++; $display("FAIL single_spi_data: got %h want 300123", spi_data); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        tick();
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", spi_start); end
        spi_busy = 1'b1;
        repeat (27) tick();
        spi_busy = 1'b0;
        checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL single_busy_held: got %b want 1", scan_busy); end
        tick();
        checks++; if ({scan_busy, grant} !== 3'b000) begin errors++; $display("FAIL single_release: got busy,grant=%b want 000", {scan_busy, grant}); end
        tick();
    endtask

    task automatic test_tie();
        apply_reset();
        tick();
        scan_start = 1'b1; scan_data = 24'hAAAAAA;
        host_start = 1'b1; host_data = 24'h555555;
        tick();
        scan_start = 1'b0; host_start = 1'b0;
        checks++; if ({scan_busy, host_busy} !== 2'b11) begin errors++; $display("FAIL tie_both_busy: got %b want 11", {scan_busy, host_busy}); end
        tick();
        checks++; if ({spi_start, grant} !== 3'b101 || spi_data !== 24'hAAAAAA) begin errors++; $display("FAIL tie_scan_first: got start,grant=%b data=%h want 101 AAAAAA", {spi_start, grant}, spi_data); end
        tick();
        spi_busy = 1'b1;
        repeat (3) tick();
        spi_busy = 1'b0;
        tick();
        checks++; if ({spi_start, grant, scan_busy, host_busy} !== 5'b00001) begin errors++; $display("FAIL tie_release: got start,grant,sb,hb=%b want 00001", {spi_start, grant, scan_busy, host_busy}); end
        tick();
        checks++; if ({spi_start, grant} !== 3'b110 || spi_data !== 24'h555555) begin errors++; $display("FAIL tie_host_second: got start,grant=%b data=%h want 110 555555", {spi_start, grant}, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); tick(); spi_busy = 1'b0;
        tick();
        // Lone scan request makes scan the last served, so the next tie goes host.
        scan_start = 1'b1; scan_data = 24'h111111;
        tick(); scan_start = 1'b0;
        tick();
        checks++; if ({spi_start, grant} !== 3'b101 || spi_data !== 24'h111111) begin errors++; $display("FAIL tie_lone_scan: got start,grant=%b data=%h want 101 111111", {spi_start, grant}, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); spi_busy = 1'b0;
        tick();
        scan_start = 1'b1; scan_data = 24'h222222;
        host_start = 1'b1; host_data = 24'h333333;
        tick(); scan_start = 1'b0; host_start = 1'b0;
        tick();
        checks++; if ({spi_start, grant} !== 3'b110 || spi_data !== 24'h333333) begin errors++; $display("FAIL tie_next_host: got start,grant=%b data=%h want 110 333333", {spi_start, grant}, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); spi_busy = 1'b0;
        tick(); tick();
        checks++; if ({spi_start, grant} !== 3'b101 || spi_data !== 24'h222222) begin errors++; $display("FAIL tie_then_scan: got start,grant=%b data=%h want 101 222222", {spi_start, grant}, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); spi_busy = 1'b0;
        tick(); tick();
    endtask

    task automatic test_overrun();
        scan_start = 1'b1; scan_data = 24'h0A0B0C;
        tick();
        scan_data = 24'h0D0E0F;
        tick();
        scan_start = 1'b0;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
        checks++; if (spi_start !== 1'b1 || spi_data !== 24'h0A0B0C) begin errors++; $display("FAIL ovr_word_kept: got start=%b data=%h want 1 0A0B0C", spi_start, spi_data); end
        tick(); spi_busy = 1'b1;
        tick();
        err_clr = 1'b1; scan_start = 1'b1; scan_data = 24'h999999;
        tick();
        err_clr = 1'b0; scan_start = 1'b0;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_clr_collide: got %b want 1", err_overrun); end
        // Start in the release cycle must be accepted, not flagged.
        spi_busy = 1'b0; err_clr = 1'b1; scan_start = 1'b1; scan_data = 24'h123456;
        tick();
        err_clr = 1'b0; scan_start = 1'b0;
        checks++; if ({err_overrun, scan_busy, grant} !== 4'b0100) begin errors++; $display("FAIL ovr_release_accept: got ovr,busy,grant=%b want 0100", {err_overrun, scan_busy, grant}); end
        tick();
        checks++; if (spi_start !== 1'b1 || spi_data !== 24'h123456) begin errors++; $display("FAIL ovr_release_word: got start=%b data=%h want 1 123456", spi_start, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); spi_busy = 1'b0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        scan_start = 1'b1; scan_data = 24'h0C0FFE;
        tick(); scan_start = 1'b0;
        tick();
        checks++; if (spi_start !== 1'b1) begin errors++; $display("FAIL to_spi_start: got %b want 1", spi_start); end
        repeat (15) tick();
        checks++; if ({err_timeout, grant} !== 3'b001) begin errors++; $display("FAIL to_edge_minus1: got err,grant=%b want 001", {err_timeout, grant}); end
        tick();
        checks++; if ({err_timeout, grant, scan_busy} !== 4'b1000) begin errors++; $display("FAIL to_expired: got err,grant,busy=%b want 1000", {err_timeout, grant, scan_busy}); end
        host_start = 1'b1; host_data = 24'h777777;
        tick(); host_start = 1'b0;
        tick();
        checks++; if ({spi_start, grant, err_timeout} !== 4'b1101 || spi_data !== 24'h777777) begin errors++; $display("FAIL to_next_served: got start,grant,err=%b data=%h want 1101 777777", {spi_start, grant, err_timeout}, spi_data); end
        tick(); spi_busy = 1'b1;
        tick(); spi_busy = 1'b0;
        tick();
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", err_timeout); end
    endtask

    task automatic test_reset_mid();
        logic bad;
        scan_start = 1'b1; scan_data = 24'h0BADF0;
        tick(); scan_start = 1'b0;
        tick();
        tick(); spi_busy = 1'b1;
        tick();
        host_start = 1'b1; host_data = 24'h0FACE0;
        tick(); host_start = 1'b0;
        checks++; if ({scan_busy, host_busy, grant} !== 4'b1101) begin errors++; $display("FAIL rstmid_setup: got sb,hb,grant=%b want 1101", {scan_busy, host_busy, grant}); end
        rst = 1'b1; host_start = 1'b1; host_data = 24'h0EEEEE;
        tick();
        rst = 1'b0; host_start = 1'b0;
        checks++; if ({grant, spi_start, scan_busy, host_busy, err_overrun, err_timeout} !== 7'b0) begin errors++; $display("FAIL rstmid_outputs: got %b want 0000000", {grant, spi_start, scan_busy, host_busy, err_overrun, err_timeout}); end
        checks++; if (spi_data !== 24'h0) begin errors++; $display("FAIL rstmid_spi_data: got %h want 000000", spi_data); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) spi_busy = 1'b0;
            tick();
            if (spi_start !== 1'b0 || host_busy !== 1'b0 || grant !== 2'b00) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got activity=%b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mems_spi_arbiter.md
MEMS_SPI_ARBITER -- requirements
Module: mems_spi_arbiter

Interface
REQ-001 Parameter DATA_W, default 24, SPI command word width.
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles from spi_start to spi_busy=1.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scan_start  input  1  scan requester command pulse, one cycle.
REQ-006 scan_data  input  DATA_W  scan command word, valid with scan_start.
REQ-007 scan_busy  output  1  scan request pending or in service.
REQ-008 host_start  input  1  host requester command pulse, one cycle.
REQ-009 host_data  input  DATA_W  host command word, valid with host_start.
REQ-010 host_busy  output  1  host request pending or in service.
REQ-011 spi_start  output  1  one-cycle start to the shared SPI master.
REQ-012 spi_data  output  DATA_W  word to the SPI master, held from spi_start until return to IDLE.
REQ-013 spi_busy  input  1  SPI master transfer in progress.
REQ-014 grant  output  2  owner: 00 none, 01 scan, 10 host.
REQ-015 err_clr  input  1  clears sticky error flags.
REQ-016 err_overrun  output  1  sticky; start received while that requester was busy.
REQ-017 err_timeout  output  1  sticky; spi_busy not seen within ACK_TIMEOUT.

Function
REQ-018 Each requester has one slot: on start with slot free, latch data and set pending at the next edge; busy = pending or granted.
REQ-019 Start while own busy=1 is dropped; slot data unchanged; err_overrun set.
REQ-020 States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE; reset to IDLE.
REQ-021 IDLE: one pending requester -> grant it; both pending -> grant the one not served last (last_grant resets to host, so scan wins first tie); go ISSUE.
REQ-022 Granted slot: pending cleared, busy remains 1 until return to IDLE.
REQ-023 ISSUE: spi_start=1 exactly one cycle, spi_data = granted word; next state WAIT_ACK.
REQ-024 Latency: start in cycle N, idle arbiter, no contention -> spi_start high in cycle N+2.
REQ-025 WAIT_ACK: spi_busy=1 -> WAIT_DONE; counter reaches ACK_TIMEOUT with spi_busy=0 -> set err_timeout, release grant, IDLE.
REQ-026 WAIT_DONE: spi_busy=0 -> release grant, update last_grant, IDLE; the requester's busy falls in the same cycle as the IDLE entry.
REQ-027 Back-to-back: other slot pending at release -> its spi_start two cycles after spi_busy falls.
REQ-028 Simultaneous scan_start and host_start: both latched; served in tie order of REQ-021.
REQ-029 Start arriving in the release cycle of the same requester: accepted (slot free at that edge).
REQ-030 err_clr and a new error in the same cycle: flag remains set.
REQ-031 grant, spi_start, busy outputs registered; no combinational path from inputs to spi_start.
REQ-032 Timeout counter width ceil(log2(ACK_TIMEOUT+1)); cleared on ISSUE entry; no wrap.

Reset
REQ-033 rst mid-operation: state IDLE, slots cleared, grant=00, spi_start=0, spi_data=0, busy outputs 0, errors 0, last_grant=host, counter 0; in-flight SPI transfer abandoned.
REQ-034 Starts in the rst cycle are ignored.

Structure
REQ-035 Package mems_spi_pkg holds state enum, grant encodings, DATA_W and ACK_TIMEOUT defaults.
REQ-036 Sub-module mems_spi_req_slot (pending latch, data capture, overrun detect) instantiated twice.

Verification
REQ-037 scan_start, scan_data=0x300123 at cycle 10 -> spi_start cycle 12, spi_data=0x300123, grant=01; spi_busy 13..40 -> scan_busy falls cycle 41.
REQ-038 Both starts same cycle (scan 0xAAAAAA, host 0x555555) after reset -> scan served first; host spi_start two cycles after spi_busy falls; next tie goes host.
REQ-039 Second scan_start while scan_busy=1 -> dropped, err_overrun=1, original word transmitted; err_clr -> err_overrun=0.
REQ-040 spi_busy held 0 after spi_start -> err_timeout=1 after 15 cycles, grant=00, scan_busy=0, next request served.
REQ-041 rst asserted during WAIT_DONE with host pending -> all outputs reset values next cycle, host request lost, no spi_start afterwards.
